// File: rtl/ps2_key_buffer.sv
// ps2_key_buffer: keystroke FIFO with line editing between PS/2 front end and CPU bus.
// Captures one byte per ps2_ready rising level, serves the CPU with a registered read.
module ps2_key_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_ready,
    input  logic [7:0]            ascii,
    input  logic                  rd_req,
    input  logic                  clr,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   lines,
    output logic                  overflow,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam logic [7:0] CODE_NUL = 8'h00;
    localparam logic [7:0] CODE_BS  = 8'h08;
    localparam logic [7:0] CODE_CR  = 8'h0D;

    logic [7:0] mem [DEPTH];

    ptr_t wptr;
    ptr_t rptr;
    logic ps2_ready_d;

    logic       key_evt;
    logic       is_bs;
    logic       is_store;
    logic       rd_ok;
    logic       bs_ok;
    logic       wr_ok;
    logic       drop;
    logic [7:0] newest;
    logic [7:0] oldest;
    ptr_t       wptr_nxt;
    ptr_t       rptr_nxt;
    cnt_t       count_nxt;
    cnt_t       lines_nxt;

    // Status flags are pure decodes of the registered counters.
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign irq   = (lines != '0) || overflow;

    // Classify the current key event and decide what the FIFO does this cycle.
    always_comb begin
        key_evt  = ps2_ready && !ps2_ready_d;
        is_bs    = (ascii == CODE_BS);
        is_store = (ascii != CODE_NUL) && !is_bs;
        newest   = mem[wptr - ptr_t'(1)];
        oldest   = mem[rptr];

        rd_ok = !clr && rd_req && !empty;

        // With a single entry, a concurrent read owns it; backspace is dropped.
        bs_ok = !clr && key_evt && is_bs && !empty
                && (newest != CODE_CR)
                && !(rd_ok && count == cnt_t'(1));

        // A full FIFO still accepts a byte if a read frees a slot this cycle.
        wr_ok = !clr && key_evt && is_store && (!full || rd_ok);
        drop  = !clr && key_evt && is_store && full && !rd_ok;

        wptr_nxt  = wptr + ptr_t'(wr_ok) - ptr_t'(bs_ok);
        rptr_nxt  = rptr + ptr_t'(rd_ok);
        count_nxt = count + cnt_t'(wr_ok)
                    - cnt_t'(rd_ok) - cnt_t'(bs_ok);
        lines_nxt = lines
                    + cnt_t'(wr_ok && ascii == CODE_CR)
                    - cnt_t'(rd_ok && oldest == CODE_CR);
    end

    // Edge detector register for the level-style keyboard strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_ready_d <= 1'b0;
        end else begin
            ps2_ready_d <= ps2_ready;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= ascii;
        end
    end

    // Pointers, occupancy, line count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            lines    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            lines    <= '0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            count    <= count_nxt;
            lines    <= lines_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered CPU read port: data holds until the next successful read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= oldest;
            end
        end
    end

endmodule

// File: doc/ps2_key_buffer.md
# ps2_key_buffer

Keystroke buffer and read controller between the PS/2 keyboard front end and the CPU bus. It captures each ASCII byte presented with the keyboard's level `ps2_ready` strobe exactly once and queues it in a circular FIFO. It applies line editing (backspace removes the last unconsumed character) and tracks complete lines. It serves the CPU through a one-cycle-latency read handshake with status and interrupt outputs.

## Interface
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ps2_ready`  in  1  keyboard byte valid; level, may stay high for many cycles, synchronous to `clk`
- `ascii`  in  8  keyboard ASCII code, valid while `ps2_ready`=1
- `rd_req`  in  1  CPU read request, one pulse per byte
- `clr`  in  1  synchronous flush
- `rd_data`  out  8  last byte read; holds until next successful read
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated
- `empty`  out  1  FIFO count = 0
- `full`  out  1  FIFO count = 2^DEPTH_LOG2
- `count`  out  DEPTH_LOG2+1  entries stored
- `lines`  out  DEPTH_LOG2+1  number of 8'h0D entries stored
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full
- `irq`  out  1  `lines` ≠ 0 or `overflow`

## Operation
- **Reset values:** all outputs 0 except `empty`=1. Pointers = 0 and `ps2_ready_d` = 0. Reset mid-operation discards the FIFO contents.
- **Capture:** `ps2_ready_d` is `ps2_ready` registered. A key event is a cycle with `ps2_ready`=1 and `ps2_ready_d`=0. A level held high produces exactly one event.
- **Event classification:**
  - `ascii` = 8'h00: ignored.
  - `ascii` = 8'h08 (backspace): if count>0 and the newest entry is not 8'h0D, decrement the write pointer and count. Otherwise ignore. Backspace is never stored.
  - Any other code: if not full, write at `wptr`, then wptr+1 and count+1. If the code is 8'h0D, also lines+1. If full, drop the byte and set `overflow`.
- **Read:** `rd_req` with count>0 gives `rd_data` ← mem[rptr], rptr+1, count−1, `rd_valid`=1 for the next cycle. If that byte is 8'h0D, lines−1. `rd_req` when empty is ignored: no `rd_valid`, `rd_data` holds.
- **Pointers:** DEPTH_LOG2 bits wide, wrap modulo depth. `count` is tracked separately so full and empty are distinguishable.
- **Simultaneous write and read:** both execute in the same cycle; count is unchanged. A write is allowed when full if a read happens in the same cycle, so no overflow is flagged. A read when empty is not satisfied by the same-cycle write.
- **Simultaneous backspace and read:**
  - count=1: the read wins and the backspace is discarded.
  - count>1: both execute and count drops by 2.
- **`clr`:** pointers, count, lines and `overflow` go to 0. Has priority over same-cycle events and reads. `rd_data` holds.
- Newest entry for the backspace check is mem[wptr−1] (modulo depth).

## Timing
- Event sampled in cycle N: the entry is written at the end of N, and `count`, `full`, `lines` and `irq` reflect it in N+1.
- `rd_req` in cycle N: `rd_data`/`rd_valid` are registered and visible in N+1. `rd_valid` is exactly one cycle wide.
- Back-to-back `rd_req` on consecutive cycles gives one byte per cycle.
- All status outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- `overflow` stays set until `clr` or `rst`.

## Test plan
- **Single key, held high:** `ps2_ready` high 5 cycles with `ascii`=8'h41 → count=1 (not 5). `rd_req` → `rd_valid` pulse one cycle later, `rd_data`=8'h41, `empty`=1.
- **Line editing:**
  - Events 'a','b',8'h08,'c',8'h0D → count=3, lines=1, `irq`=1.
  - Three reads return 8'h61, 8'h63, 8'h0D; lines=0 and `irq`=0 after the last read.
  - A further 8'h08 after 8'h0D is ignored.
- **Overflow and wrap:**
  - 17 distinct events (bytes 8'h30..8'h40) → `full`=1, count=16, `overflow`=1.
  - 16 reads return 8'h30..8'h3F in order.
  - Then write and read 20 more bytes across the pointer wrap with the data order preserved.
- **Simultaneous read and write when full:** key event and `rd_req` in the same cycle → count stays 16, `overflow` unchanged, oldest byte read.
- **Read when empty, and backspace with count=1:**
  - `rd_req` when empty → no `rd_valid`.
  - With one entry, backspace and `rd_req` in the same cycle → `rd_data` = that entry and count=0.
- **Reset and clr:**
  - Assert `rst` mid-stream, between capture and read → all outputs at reset values immediately, asynchronously.
  - With 5 entries and `overflow`=1, `clr` → count=0, lines=0, `overflow`=0, `irq`=0, `rd_data` unchanged.
